// File: rtl/three_to_eight_pulse_decoder.sv
// three_to_eight_pulse_decoder
//
// Re-expands a binary index into a timed one-hot strobe. An accepted index drives
// out = 1 << in_idx for PULSE_LEN cycles. The output is then forced to zero for
// GAP_LEN cycles before the next index can be accepted.
//
// Parameters:
//   OUT_W      one-hot output width (IDX_W = $clog2(OUT_W))
//   PULSE_LEN  cycles the one-hot output is held (1..255)
//   GAP_LEN    forced all-zero cycles after each pulse (0..255)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_valid  index offered
//   in_ready  block can accept (high only while idle)
//   in_idx    index to decode, sampled only on accept
//   out       registered one-hot (or all-zero) output
//   busy      pulse or gap in progress
//   done      high during the final pulse cycle
//
// Optional feature (define PARITY_CHK_EN):
//   in_par    even parity of in_idx supplied with the transfer
//   err       sticky parity error flag, cleared only by rst. A transfer with bad
//             parity is consumed and produces no pulse.
module three_to_eight_pulse_decoder #(
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1,
    localparam int unsigned IDX_W    = $clog2(OUT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
`ifdef PARITY_CHK_EN
    input  logic             in_par,
    output logic             err,
`endif
    output logic [OUT_W-1:0] out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    // Terminal counts of the shared phase counter. GapLast is unused when GAP_LEN is 0.
    localparam logic [7:0] PulseLast = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GapLast   = 8'(GAP_LEN - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             accept;
    logic             idx_ok;
    logic             par_ok;
    logic [OUT_W-1:0] onehot;

    assign accept = in_valid && in_ready;
    // Only reachable for non-power-of-two OUT_W: such indices are consumed but dropped.
    assign idx_ok = (32'(in_idx) < OUT_W);
    assign onehot = {{(OUT_W-1){1'b0}}, 1'b1} << in_idx;

`ifdef PARITY_CHK_EN
    logic err_q, err_d;

    assign par_ok = (in_par == ^in_idx);
    assign err_d  = err_q | (accept && !par_ok);
    assign err    = err_q;
`else
    assign par_ok = 1'b1;
`endif

    // State register. The latched one-hot value doubles as the captured index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            out_q   <= '0;
`ifdef PARITY_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
`ifdef PARITY_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            StIdle: begin
                if (accept && idx_ok && par_ok) begin
                    state_d = StPulse;
                    cnt_d   = 8'd0;
                    out_d   = onehot;
                end
            end
            StPulse: begin
                if (cnt_q == PulseLast) begin
                    state_d = (GAP_LEN == 0) ? StIdle : StGap;
                    cnt_d   = 8'd0;
                    out_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
                out_d   = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready = (state_q == StIdle);
        busy     = (state_q != StIdle);
        done     = (state_q == StPulse) && (cnt_q == PulseLast);
        out      = out_q;
    end

endmodule

// File: tb/tb_three_to_eight_pulse_decoder.sv
module tb_three_to_eight_pulse_decoder;

    localparam int P0 = 4;
    localparam int G0 = 1;
    localparam int P1 = 1;
    localparam int G1 = 0;
    localparam int N  = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_idx = 3'd0;
    logic       in_ready0, busy0, done0;
    logic       in_ready1, busy1, done1;
    logic [7:0] out0, out1;
`ifdef PARITY_CHK_EN
    logic       in_par = 1'b0;
    logic       par_flip = 1'b0;
    logic       err0, err1;
    bit         e_err [2];
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Expected timeline per DUT, indexed by cycle number (cycle k = after k-th edge).
    bit [7:0] e_out  [2][N];
    bit       e_done [2][N];
    bit       e_busy [2][N];

    three_to_eight_pulse_decoder #(.OUT_W(8), .PULSE_LEN(P0), .GAP_LEN(G0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready0),
        .in_idx   (in_idx),
`ifdef PARITY_CHK_EN
        .in_par   (in_par),
        .err      (err0),
`endif
        .out      (out0),
        .busy     (busy0),
        .done     (done0)
    );

    three_to_eight_pulse_decoder #(.OUT_W(8), .PULSE_LEN(P1), .GAP_LEN(G1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready1),
        .in_idx   (in_idx),
`ifdef PARITY_CHK_EN
        .in_par   (in_par),
        .err      (err1),
`endif
        .out      (out1),
        .busy     (busy1),
        .done     (done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Apply the transfer rules for the coming edge: a reset wipes the future, an
    // accepted index schedules p pulse cycles followed by g gap cycles.
    task automatic model_edge(input int d, input int p, input int g);
        int k;
        k = cyc;
        if (rst) begin
            for (int i = k + 1; i < N; i++) begin
                e_out[d][i]  = 8'h00;
                e_done[d][i] = 1'b0;
                e_busy[d][i] = 1'b0;
            end
`ifdef PARITY_CHK_EN
            e_err[d] = 1'b0;
`endif
        end else if (in_valid && !e_busy[d][k]) begin
`ifdef PARITY_CHK_EN
            if (in_par != ^in_idx) begin
                e_err[d] = 1'b1;
                return;
            end
`endif
            for (int i = 1; i <= p; i++) e_out[d][k + i] = 8'd1 << in_idx;
            e_done[d][k + p] = 1'b1;
            for (int i = 1; i <= p + g; i++) e_busy[d][k + i] = 1'b1;
        end
    endtask

    task automatic step();
`ifdef PARITY_CHK_EN
        in_par = (^in_idx) ^ par_flip;
`endif
        model_edge(0, P0, G0);
        model_edge(1, P1, G1);
        @(posedge clk);
        cyc++;
        #1;
        chk("out0",   {24'd0, out0},  {24'd0, e_out[0][cyc]});
        chk("done0",  {31'd0, done0}, {31'd0, e_done[0][cyc]});
        chk("busy0",  {31'd0, busy0}, {31'd0, e_busy[0][cyc]});
        chk("ready0", {31'd0, in_ready0}, {31'd0, !e_busy[0][cyc]});
        chk("out1",   {24'd0, out1},  {24'd0, e_out[1][cyc]});
        chk("done1",  {31'd0, done1}, {31'd0, e_done[1][cyc]});
        chk("busy1",  {31'd0, busy1}, {31'd0, e_busy[1][cyc]});
        chk("ready1", {31'd0, in_ready1}, {31'd0, !e_busy[1][cyc]});
`ifdef PARITY_CHK_EN
        chk("err0", {31'd0, err0}, {31'd0, e_err[0]});
        chk("err1", {31'd0, err1}, {31'd0, e_err[1]});
`endif
    endtask

    initial begin
        // Reset for two cycles
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Single index 5
        in_valid = 1'b1;
        in_idx   = 3'd5;
        step();
        in_valid = 1'b0;
        repeat (7) step();

        // Valid held: index 0, then 7 waits for the next ready edge
        in_valid = 1'b1;
        in_idx   = 3'd0;
        step();
        in_idx = 3'd7;
        repeat (10) step();
        in_valid = 1'b0;
        repeat (6) step();

        // Index changes during a pulse are ignored
        in_valid = 1'b1;
        in_idx   = 3'd2;
        step();
        in_valid = 1'b0;
        in_idx   = 3'd6;
        repeat (2) step();
        in_idx = 3'd3;
        repeat (5) step();

        // Reset during the second pulse cycle aborts the pulse
        in_valid = 1'b1;
        in_idx   = 3'd4;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();

`ifdef PARITY_CHK_EN
        // Bad parity: consumed, no pulse, sticky error; good parity then decodes
        in_valid = 1'b1;
        in_idx   = 3'd3;
        par_flip = 1'b1;
        step();
        par_flip = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (6) step();
`endif

        // Randomized traffic with occasional resets
        repeat (400) begin
            rst      = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_idx   = 3'($urandom);
`ifdef PARITY_CHK_EN
            par_flip = ($urandom_range(0, 9) == 0);
`endif
            step();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
`ifdef PARITY_CHK_EN
        par_flip = 1'b0;
`endif
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
